// File: rtl/dmem_arbiter_if.sv
// Bundle of both requester ports and the single-port memory bus seen by dmem_arbiter.
// The arbiter uses the slave view; the requesters and memory model use the master view.
interface dmem_arbiter_if #(
    parameter int DATA_W = 32
);
    logic              p0_req;
    logic              p0_we;
    logic [DATA_W-1:0] p0_addr;
    logic [DATA_W-1:0] p0_wdata;
    logic              p0_gnt;
    logic              p0_rvalid;
    logic [DATA_W-1:0] p0_rdata;
    logic              p0_err;

    logic              p1_req;
    logic              p1_we;
    logic [DATA_W-1:0] p1_addr;
    logic [DATA_W-1:0] p1_wdata;
    logic              p1_gnt;
    logic              p1_rvalid;
    logic [DATA_W-1:0] p1_rdata;
    logic              p1_err;

    logic              mem_write;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  p0_req, p0_we, p0_addr, p0_wdata,
        output p0_gnt, p0_rvalid, p0_rdata, p0_err,
        input  p1_req, p1_we, p1_addr, p1_wdata,
        output p1_gnt, p1_rvalid, p1_rdata, p1_err,
        output mem_write, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output p0_req, p0_we, p0_addr, p0_wdata,
        input  p0_gnt, p0_rvalid, p0_rdata, p0_err,
        output p1_req, p1_we, p1_addr, p1_wdata,
        input  p1_gnt, p1_rvalid, p1_rdata, p1_err,
        input  mem_write, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of the single-port data memory.
// Grants one access per cycle, rejects misaligned/out-of-range addresses and
// returns a registered one-cycle response to the winning port.
module dmem_arbiter #(
    parameter int DATA_W        = 32,
    parameter int DEPTH_WORDS   = 128,
    parameter int PRIORITY_INIT = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    dmem_arbiter_if.slave        bus,
    output logic [15:0]          conflict_cnt
);

    typedef enum logic {
        PRIO_P0 = 1'b0,
        PRIO_P1 = 1'b1
    } prio_e;

    localparam logic [DATA_W-1:0] ADDR_LIMIT = DATA_W'(DEPTH_WORDS * 4);
    localparam prio_e             PRIO_RST   = (PRIORITY_INIT != 0) ? PRIO_P1 : PRIO_P0;

    prio_e             rr_ptr_q, rr_ptr_d;
    logic              gnt0, gnt1;
    logic              sel_we;
    logic [DATA_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              addr_ok;

    logic              rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
    logic              err0_q, err0_d, err1_q, err1_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic [15:0]       conflict_q, conflict_d;

    // Grant decision: lone requester wins, contention resolved by rr_ptr, nothing during reset.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!reset) begin
            if (bus.p0_req && bus.p1_req) begin
                gnt0 = (rr_ptr_q == PRIO_P0);
                gnt1 = (rr_ptr_q == PRIO_P1);
            end else begin
                gnt0 = bus.p0_req;
                gnt1 = bus.p1_req;
            end
        end
    end

    // Route the winner onto the memory bus, check its address, and compute next state.
    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        if (gnt0) begin
            sel_we    = bus.p0_we;
            sel_addr  = bus.p0_addr;
            sel_wdata = bus.p0_wdata;
        end else if (gnt1) begin
            sel_we    = bus.p1_we;
            sel_addr  = bus.p1_addr;
            sel_wdata = bus.p1_wdata;
        end
        addr_ok = (sel_addr[1:0] == 2'b00) && (sel_addr < ADDR_LIMIT);

        rr_ptr_d = rr_ptr_q;
        if (gnt0) begin
            rr_ptr_d = PRIO_P1;
        end else if (gnt1) begin
            rr_ptr_d = PRIO_P0;
        end

        rvalid0_d = gnt0;
        rvalid1_d = gnt1;
        err0_d    = gnt0 && !addr_ok;
        err1_d    = gnt1 && !addr_ok;
        rdata0_d  = (gnt0 && !sel_we && addr_ok) ? bus.mem_rdata : '0;
        rdata1_d  = (gnt1 && !sel_we && addr_ok) ? bus.mem_rdata : '0;

        conflict_d = conflict_q;
        if (bus.p0_req && bus.p1_req && (conflict_q != '1)) begin
            conflict_d = conflict_q + 16'd1;
        end
    end

    // State and response registers; reset drops any pending response.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_q   <= PRIO_RST;
            rvalid0_q  <= 1'b0;
            rvalid1_q  <= 1'b0;
            err0_q     <= 1'b0;
            err1_q     <= 1'b0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
            conflict_q <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            rvalid0_q  <= rvalid0_d;
            rvalid1_q  <= rvalid1_d;
            err0_q     <= err0_d;
            err1_q     <= err1_d;
            rdata0_q   <= rdata0_d;
            rdata1_q   <= rdata1_d;
            conflict_q <= conflict_d;
        end
    end

    assign bus.p0_gnt    = gnt0;
    assign bus.p1_gnt    = gnt1;
    assign bus.mem_write = (gnt0 || gnt1) && sel_we && addr_ok;
    assign bus.mem_addr  = sel_addr;
    assign bus.mem_wdata = sel_wdata;
    assign bus.p0_rvalid = rvalid0_q;
    assign bus.p0_err    = err0_q;
    assign bus.p0_rdata  = rdata0_q;
    assign bus.p1_rvalid = rvalid1_q;
    assign bus.p1_err    = err1_q;
    assign bus.p1_rdata  = rdata1_q;
    assign conflict_cnt  = conflict_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: requester drivers, a memory model, a
// rule-level reference that predicts grants/responses, and a response monitor.
`timescale 1ns/1ps
module tb_dmem_arbiter;

    localparam int DW    = 32;
    localparam int DEPTH = 128;
    localparam int PINIT = 0;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] conflict_cnt;

    always #5 clk = ~clk;

    dmem_arbiter_if #(.DATA_W(DW)) bus();

    dmem_arbiter #(
        .DATA_W(DW),
        .DEPTH_WORDS(DEPTH),
        .PRIORITY_INIT(PINIT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus),
        .conflict_cnt(conflict_cnt)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          gap;
    } tx_t;

    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    exp_t q0[$];
    exp_t q1[$];
    tx_t  txq0[$];
    tx_t  txq1[$];
    logic busy [2];
    int   prio = PINIT;
    int   cnt_m = 0;
    logic [31:0] ram [DEPTH];
    logic [31:0] model_mem [DEPTH];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] init_val(input int i);
        if (i == 0) return 32'd15;
        if (i == 1) return 32'd20;
        return (32'(i) * 32'h0101_0101) ^ 32'hA5A5_0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory model: combinational read, write on clock, reloaded with known contents in reset.
    assign bus.mem_rdata = (bus.mem_addr < 32'(DEPTH * 4)) ? ram[bus.mem_addr[8:2]] : 32'hDEAD_BEEF;
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) ram[i] <= init_val(i);
        end else if (bus.mem_write) begin
            ram[bus.mem_addr[8:2]] <= bus.mem_wdata;
        end
    end

    // Reference: predict grant and memory bus from the arbitration rules, push expected responses.
    always @(negedge clk) begin
        int          w;
        logic        we, ok;
        logic [31:0] addr, wdata;
        exp_t        e;
        check("conflict_cnt", 32'(conflict_cnt), 32'(cnt_m));
        if (reset) begin
            check("gnt0_in_reset", 32'(bus.p0_gnt), 32'd0);
            check("gnt1_in_reset", 32'(bus.p1_gnt), 32'd0);
            check("mem_write_in_reset", 32'(bus.mem_write), 32'd0);
            prio  = PINIT;
            cnt_m = 0;
            q0.delete();
            q1.delete();
            for (int i = 0; i < DEPTH; i++) model_mem[i] = init_val(i);
        end else begin
            if (bus.p0_req && bus.p1_req) begin
                w = prio;
                if (cnt_m < 65535) cnt_m++;
            end else if (bus.p0_req) w = 0;
            else if (bus.p1_req) w = 1;
            else w = -1;
            check("gnt0", 32'(bus.p0_gnt), 32'(w == 0));
            check("gnt1", 32'(bus.p1_gnt), 32'(w == 1));
            if (w >= 0) begin
                we    = (w == 0) ? bus.p0_we    : bus.p1_we;
                addr  = (w == 0) ? bus.p0_addr  : bus.p1_addr;
                wdata = (w == 0) ? bus.p0_wdata : bus.p1_wdata;
                ok    = (addr % 4 == 0) && (addr < 32'(DEPTH * 4));
                check("mem_addr", bus.mem_addr, addr);
                check("mem_wdata", bus.mem_wdata, wdata);
                check("mem_write", 32'(bus.mem_write), 32'(we && ok));
                e.err   = !ok;
                e.rdata = (!we && ok) ? model_mem[addr / 4] : 32'd0;
                e.cyc   = cyc;
                if (we && ok) model_mem[addr / 4] = wdata;
                if (w == 0) q0.push_back(e); else q1.push_back(e);
                prio = 1 - w;
            end else begin
                check("mem_write_idle", 32'(bus.mem_write), 32'd0);
                check("mem_addr_idle", bus.mem_addr, 32'd0);
                check("mem_wdata_idle", bus.mem_wdata, 32'd0);
            end
        end
    end

    task automatic mon(input int k, input logic rv, input logic [31:0] rd, input logic er);
        exp_t e;
        int   n;
        n = (k == 0) ? q0.size() : q1.size();
        if (rv) begin
            if (n == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL rvalid%0d: response rdata %h err %0b, expected none (cycle %0d)", k, rd, er, cyc);
            end else begin
                if (k == 0) e = q0.pop_front(); else e = q1.pop_front();
                check($sformatf("rsp%0d_latency", k), 32'(cyc), 32'(e.cyc + 1));
                check($sformatf("rsp%0d_rdata", k), rd, e.rdata);
                check($sformatf("rsp%0d_err", k), 32'(er), 32'(e.err));
            end
        end else begin
            check($sformatf("idle%0d_rdata", k), rd, 32'd0);
            check($sformatf("idle%0d_err", k), 32'(er), 32'd0);
            if (n > 0) begin
                if (k == 0) e = q0[0]; else e = q1[0];
                if (e.cyc < cyc) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL rvalid%0d_missing: got 0, expected 1 for grant in cycle %0d", k, e.cyc);
                    if (k == 0) void'(q0.pop_front()); else void'(q1.pop_front());
                end
            end
        end
    endtask

    // Monitor: consume expected responses whenever a port presents one.
    always @(negedge clk) begin
        if (!reset) begin
            mon(0, bus.p0_rvalid, bus.p0_rdata, bus.p0_err);
            mon(1, bus.p1_rvalid, bus.p1_rdata, bus.p1_err);
        end
    end

    task automatic put(input int k, input tx_t t, input logic rq);
        if (k == 0) begin
            bus.p0_req = rq;
            if (rq) begin bus.p0_we = t.we; bus.p0_addr = t.addr; bus.p0_wdata = t.wdata; end
        end else begin
            bus.p1_req = rq;
            if (rq) begin bus.p1_we = t.we; bus.p1_addr = t.addr; bus.p1_wdata = t.wdata; end
        end
    endtask

    // Requester drivers: hold each request stable until granted, then fetch the next.
    initial begin
        logic g [2];
        int   gapc [2];
        int   waitc [2];
        tx_t  t;
        t = '{we: 1'b0, addr: 32'd0, wdata: 32'd0, gap: 0};
        bus.p0_req = 1'b0; bus.p0_we = 1'b0; bus.p0_addr = '0; bus.p0_wdata = '0;
        bus.p1_req = 1'b0; bus.p1_we = 1'b0; bus.p1_addr = '0; bus.p1_wdata = '0;
        for (int k = 0; k < 2; k++) begin busy[k] = 1'b0; gapc[k] = 0; waitc[k] = 0; end
        forever begin
            @(negedge clk);
            g[0] = bus.p0_gnt;
            g[1] = bus.p1_gnt;
            @(posedge clk);
            #1;
            for (int k = 0; k < 2; k++) begin
                if (busy[k]) begin
                    if (g[k]) begin
                        busy[k] = 1'b0;
                        put(k, t, 1'b0);
                    end else if (++waitc[k] > 64) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL gnt%0d_timeout: got no grant, expected one within 64 cycles", k);
                        busy[k] = 1'b0;
                        put(k, t, 1'b0);
                    end
                end
                if (!busy[k] && ((k == 0) ? txq0.size() : txq1.size()) > 0) begin
                    if (gapc[k] < ((k == 0) ? txq0[0].gap : txq1[0].gap)) begin
                        gapc[k]++;
                    end else begin
                        if (k == 0) t = txq0.pop_front(); else t = txq1.pop_front();
                        gapc[k]  = 0;
                        waitc[k] = 0;
                        busy[k]  = 1'b1;
                        put(k, t, 1'b1);
                    end
                end
            end
        end
    end

    task automatic push(input int k, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input int gap);
        tx_t t;
        t.we = we; t.addr = addr; t.wdata = wdata; t.gap = gap;
        if (k == 0) txq0.push_back(t); else txq1.push_back(t);
    endtask

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        while (txq0.size() != 0 || txq1.size() != 0 || busy[0] || busy[1]) begin
            @(negedge clk);
            if (++n > limit) begin
                vectors++;
                miscompares++;
                $display("FAIL idle_timeout: got busy after %0d cycles, expected idle", limit);
                break;
            end
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic mem_compare(input string tag);
        for (int i = 0; i < DEPTH; i++) check($sformatf("%s_word%0d", tag, i), ram[i], model_mem[i]);
    endtask

    initial begin
        logic [31:0] a;
        int          n;
        #2_000_000;
        $display("FAIL watchdog: got no finish, expected finish before 2 ms");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        int          n;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Lone read of word 0.
        push(0, 1'b0, 32'd0, 32'd0, 0);
        wait_idle(100);

        // Simultaneous requests from reset: p0 first, p1 next.
        do_reset();
        push(0, 1'b0, 32'd4, 32'd0, 0);
        push(1, 1'b0, 32'd0, 32'd0, 0);
        wait_idle(100);
        check("cnt_after_pair", 32'(conflict_cnt), 32'd1);

        // Write then read-after-write from the other port.
        do_reset();
        push(1, 1'b1, 32'd8, 32'h55, 0);
        push(0, 1'b0, 32'd8, 32'd0, 1);
        wait_idle(100);

        // Misaligned and out-of-range writes.
        do_reset();
        push(0, 1'b1, 32'd6, 32'h1234, 0);
        push(1, 1'b1, 32'd512, 32'h5678, 0);
        wait_idle(100);
        mem_compare("bad_wr");
        check("word1_kept", ram[1], 32'd20);
        check("word2_kept", ram[2], init_val(2));

        // Six cycles of continuous contention.
        do_reset();
        for (int i = 0; i < 4; i++) push(0, 1'b0, 32'(i * 4), 32'd0, 0);
        for (int i = 0; i < 3; i++) push(1, 1'b0, 32'(i * 4 + 16), 32'd0, 0);
        wait_idle(100);
        check("cnt_after_six", 32'(conflict_cnt), 32'd6);

        // Reset in the cycle after a p0 grant, with both ports requesting through reset.
        do_reset();
        push(0, 1'b0, 32'd0, 32'd0, 0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.p0_gnt && n < 50);
        check("p0_gnt_seen", 32'(bus.p0_gnt), 32'd1);
        @(posedge clk);
        #1 reset = 1'b1;
        push(0, 1'b0, 32'd4, 32'd0, 0);
        push(1, 1'b0, 32'd0, 32'd0, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rvalid0_after_reset", 32'(bus.p0_rvalid), 32'd0);
        check("prio_after_reset", 32'(bus.p0_gnt), 32'd1);
        wait_idle(100);

        // Randomized traffic with gaps, errors and read-after-write hazards.
        do_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 300; i++) begin
                case ($urandom_range(0, 9))
                    0:       a = 32'(DEPTH * 4) + 32'($urandom_range(0, 15)) * 4;
                    1:       a = 32'($urandom_range(0, 63)) * 4 + 32'($urandom_range(1, 3));
                    2:       a = 32'hFFFF_FFFC;
                    default: a = 32'($urandom_range(0, 15)) * 4;
                endcase
                push(k, 1'($urandom_range(0, 1)), a, $urandom, $urandom_range(0, 3));
            end
        end
        wait_idle(5000);
        mem_compare("random");

        // Sustained contention long enough to saturate the conflict counter.
        do_reset();
        for (int i = 0; i < 32770; i++) begin
            push(0, 1'b0, 32'd0, 32'd0, 0);
            push(1, 1'b0, 32'd4, 32'd0, 0);
        end
        wait_idle(70000);
        check("cnt_saturated", 32'(conflict_cnt), 32'h0000_FFFF);
        check("q0_drained", 32'(q0.size()), 32'd0);
        check("q1_drained", 32'(q1.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
